// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: steers FIR output samples into a two-bank ping-pong buffer
// of 16-sample frames and hands each filled bank to the FFT engine in fill
// order. It stops after NFRAMES frames have been processed.
module fft_frame_ctrl #(
    parameter int NFRAMES = 62
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fir_valid,
    input  logic signed [15:0] fir_d,
    output logic               buf_we,
    output logic               buf_wbank,
    output logic [3:0]         buf_waddr,
    output logic signed [15:0] buf_wdata,
    input  logic               fft_ready,
    output logic               fft_start,
    output logic               fft_bank,
    input  logic               fft_valid,
    output logic               frame_done,
    output logic [7:0]         frame_cnt,
    output logic               overrun,
    output logic               all_done
);

    localparam logic [7:0] LAST_FRAME = 8'(NFRAMES);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] waddr;
    logic       wbank;
    logic       rd_bank;
    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       accept;
    logic       drop;
    logic       release_bank;

    // A sample lands only if the bank being written is free and the run is
    // not finished; once finished, samples vanish without raising overrun.
    assign accept    = fir_valid & ~full[wbank] & ~all_done;
    assign drop      = fir_valid &  full[wbank] & ~all_done;
    assign buf_we    = accept;
    assign buf_wbank = wbank;
    assign buf_waddr = waddr;
    assign buf_wdata = fir_d;
    assign fft_bank  = rd_bank;

    // Dispatch decision: start the FFT on the oldest full bank, then wait for its result.
    always_comb begin
        state_nxt    = state;
        fft_start    = 1'b0;
        release_bank = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank] && fft_ready && !all_done) begin
                    state_nxt = START;
                end
            end
            START: begin
                fft_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (fft_valid) begin
                    release_bank = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bank occupancy: a release and a fill can land in the same cycle; they
    // always concern different banks, so both are applied.
    always_comb begin
        full_nxt = full;
        if (release_bank) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (accept && (waddr == 4'd15)) begin
            full_nxt[wbank] = 1'b1;
        end
    end

    // Dispatch state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write pointer: advances per accepted sample, moving to the other bank after address 15.
    always_ff @(posedge clk) begin
        if (!rst) begin
            waddr <= 4'd0;
            wbank <= 1'b0;
        end else if (accept) begin
            waddr <= waddr + 4'd1;
            if (waddr == 4'd15) begin
                wbank <= ~wbank;
            end
        end
    end

    // Bank flags, read pointer, frame accounting and sticky status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full       <= 2'b00;
            rd_bank    <= 1'b0;
            frame_cnt  <= 8'd0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            all_done   <= 1'b0;
        end else begin
            full       <= full_nxt;
            frame_done <= release_bank;
            if (release_bank) begin
                rd_bank <= ~rd_bank;
                if (frame_cnt != LAST_FRAME) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
                if ((frame_cnt + 8'd1) == LAST_FRAME) begin
                    all_done <= 1'b1;
                end
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: two instances (default NFRAMES and NFRAMES=2)
// share the stimulus and are compared every cycle against a frame-level model.
module tb_fft_frame_ctrl;

    localparam int N0 = 62;
    localparam int N1 = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fir_valid = 1'b0;
    logic        fft_ready = 1'b0;
    logic        fft_valid = 1'b0;
    logic [15:0] fir_d = 16'h0;

    logic [1:0]  we, wbank, start, fbank, fdone, ovr, adone;
    logic [3:0]  waddr [2];
    logic [15:0] wdata [2];
    logic [7:0]  fcnt  [2];

    int checks = 0;
    int errors = 0;

    // model state: samples accepted since reset, frames finished, bank flags
    int  m_acc   [2];
    int  m_cnt   [2];
    bit  m_full  [2][2];
    bit  m_ovr   [2];
    bit  m_fd    [2];
    bit  m_start [2];
    bit  m_busy  [2];
    int  nf      [2];
    bit  armed = 1'b0;

    logic       s_we, s_wbank;
    logic [3:0] s_waddr;

    always #5 clk = ~clk;

    fft_frame_ctrl dut0 (
        .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
        .buf_we(we[0]), .buf_wbank(wbank[0]), .buf_waddr(waddr[0]), .buf_wdata(wdata[0]),
        .fft_ready(fft_ready), .fft_start(start[0]), .fft_bank(fbank[0]),
        .fft_valid(fft_valid), .frame_done(fdone[0]), .frame_cnt(fcnt[0]),
        .overrun(ovr[0]), .all_done(adone[0])
    );

    fft_frame_ctrl #(.NFRAMES(N1)) dut1 (
        .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
        .buf_we(we[1]), .buf_wbank(wbank[1]), .buf_waddr(waddr[1]), .buf_wdata(wdata[1]),
        .fft_ready(fft_ready), .fft_start(start[1]), .fft_bank(fbank[1]),
        .fft_valid(fft_valid), .frame_done(fdone[1]), .frame_cnt(fcnt[1]),
        .overrun(ovr[1]), .all_done(adone[1])
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_inst(input int i);
        int wb;
        bit fin;
        bit exp_we;
        wb     = (m_acc[i] / 16) % 2;
        fin    = (m_cnt[i] == nf[i]);
        exp_we = fir_valid && !m_full[i][wb] && !fin;
        check($sformatf("u%0d_we", i),     int'(we[i]),    int'(exp_we));
        check($sformatf("u%0d_wbank", i),  int'(wbank[i]), wb);
        check($sformatf("u%0d_waddr", i),  int'(waddr[i]), m_acc[i] % 16);
        check($sformatf("u%0d_wdata", i),  int'(wdata[i]), int'(fir_d));
        check($sformatf("u%0d_start", i),  int'(start[i]), int'(m_start[i]));
        check($sformatf("u%0d_fbank", i),  int'(fbank[i]), m_cnt[i] % 2);
        check($sformatf("u%0d_fdone", i),  int'(fdone[i]), int'(m_fd[i]));
        check($sformatf("u%0d_fcnt", i),   int'(fcnt[i]),  m_cnt[i]);
        check($sformatf("u%0d_ovr", i),    int'(ovr[i]),   int'(m_ovr[i]));
        check($sformatf("u%0d_adone", i),  int'(adone[i]), int'(fin));
    endtask

    task automatic step_model(input int i);
        int wb, rb;
        bit fin, rel, rb_full;
        if (!rst) begin
            m_acc[i] = 0; m_cnt[i] = 0; m_full[i][0] = 1'b0; m_full[i][1] = 1'b0;
            m_ovr[i] = 1'b0; m_fd[i] = 1'b0; m_start[i] = 1'b0; m_busy[i] = 1'b0;
        end else begin
            wb      = (m_acc[i] / 16) % 2;
            rb      = m_cnt[i] % 2;
            fin     = (m_cnt[i] == nf[i]);
            rb_full = m_full[i][rb];
            rel     = m_busy[i] && fft_valid;
            if (fir_valid && !fin) begin
                if (m_full[i][wb]) m_ovr[i] = 1'b1;
                else begin
                    m_acc[i]++;
                    if (m_acc[i] % 16 == 0) m_full[i][wb] = 1'b1;
                end
            end
            if (rel) begin
                m_full[i][rb] = 1'b0;
                m_cnt[i]++;
                m_busy[i] = 1'b0;
            end else if (m_start[i]) begin
                m_start[i] = 1'b0;
                m_busy[i]  = 1'b1;
            end else if (!m_busy[i] && rb_full && fft_ready && !fin) begin
                m_start[i] = 1'b1;
            end
            m_fd[i] = rel;
        end
    endtask

    // one clock: drive at negedge, compare, advance model at posedge
    task automatic cyc(input logic r, input logic v, input logic [15:0] d,
                       input logic rdy, input logic fv);
        @(negedge clk);
        rst = r; fir_valid = v; fir_d = d; fft_ready = rdy; fft_valid = fv;
        #1;
        if (armed) begin
            compare_inst(0);
            compare_inst(1);
        end
        s_we = we[0]; s_wbank = wbank[0]; s_waddr = waddr[0];
        @(posedge clk);
        step_model(0);
        step_model(1);
        if (!r) armed = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        repeat (2) cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        int n, m;
        nf[0] = N0;
        nf[1] = N1;

        // reset state
        do_reset();
        check("rst_cnt",   int'(fcnt[0]),  0);
        check("rst_start", int'(start[0]), 0);
        check("rst_fdone", int'(fdone[0]), 0);
        check("rst_ovr",   int'(ovr[0]),   0);
        check("rst_adone", int'(adone[0]), 0);

        // 16 contiguous samples into bank 0
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b1, 16'(k * 3 + 7), 1'b1, 1'b0);
            check("seq_we",   int'(s_we),    1);
            check("seq_addr", int'(s_waddr), k);
            check("seq_bank", int'(s_wbank), 0);
        end
        check("start_early", int'(start[0]), 0);
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        check("start_pulse", int'(start[0]), 1);
        check("start_bank",  int'(fbank[0]), 0);
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        check("start_once",  int'(start[0]), 0);
        repeat (3) cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        check("fdone_pulse", int'(fdone[0]), 1);
        check("cnt_one",     int'(fcnt[0]),  1);
        check("bank_next",   int'(fbank[0]), 1);
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        check("fdone_once",  int'(fdone[0]), 0);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b1, 16'($urandom), 1'b1, 1'b0);
            check("b1_bank", int'(s_wbank), 1);
        end
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        check("b1_start",      int'(start[0]), 1);
        check("b1_start_bank", int'(fbank[0]), 1);
        repeat (2) cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        check("cnt_two", int'(fcnt[0]), 2);

        // 48 samples with no FFT result: both banks fill, the rest drop
        do_reset();
        n = 0; m = 0;
        for (int k = 0; k < 48; k++) begin
            cyc(1'b1, 1'b1, 16'($urandom), 1'b1, 1'b0);
            if (k < 32) m += int'(s_we);
            else        n += int'(s_we);
        end
        check("fill_we", m, 32);
        check("drop_we", n, 0);
        check("ovr_set", int'(ovr[0]), 1);

        // engine not ready: no start until fft_ready rises
        do_reset();
        for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, 16'($urandom), 1'b0, 1'b0);
        n = 0;
        repeat (6) begin
            cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
            n += int'(start[0]);
        end
        check("no_start", n, 0);
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        check("start_on_ready", int'(start[0]), 1);
        repeat (3) cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

        // NFRAMES=2 instance with prompt results
        do_reset();
        n = 0;
        for (int k = 0; k < 64; k++) begin
            cyc(1'b1, 1'b1, 16'($urandom), 1'b1, 1'b1);
            n += int'(start[1]);
        end
        repeat (4) begin
            cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
            n += int'(start[1]);
        end
        check("n2_starts", n, 2);
        check("n2_cnt",    int'(fcnt[1]),  2);
        check("n2_done",   int'(adone[1]), 1);
        check("n2_ovr",    int'(ovr[1]),   0);

        // reset while waiting for a result abandons the frame
        do_reset();
        for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, 16'($urandom), 1'b1, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        n = 0;
        repeat (4) begin
            cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
            n += int'(fdone[0]) + int'(start[0]);
        end
        check("rw_cnt",    int'(fcnt[0]), 0);
        check("rw_quiet",  n, 0);
        cyc(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);
        check("rw_we",     int'(s_we),    1);
        check("rw_addr",   int'(s_waddr), 0);

        // randomized traffic
        for (int c = 0; c < 6000; c++) begin
            cyc(1'($urandom_range(0, 1499) != 0),
                1'($urandom_range(0, 3) != 0),
                16'($urandom),
                1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
